// File: rtl/mac_lanes_if.sv
// Operand/result bundle for mac_lanes: control and operands in, per-lane accumulators and status out.
interface mac_lanes_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
);
  logic                            En;
  logic                            Clr;
  logic [NUM_LANES*DATA_WIDTH-1:0] Ain;
  logic [NUM_LANES*DATA_WIDTH-1:0] Bin;
  logic [NUM_LANES*ACC_WIDTH-1:0]  Cout;
  logic [NUM_LANES-1:0]            Ovf;
  logic                            Out_valid;
  logic [CNT_WIDTH-1:0]            Count;

  modport master (
    output En, Clr, Ain, Bin,
    input  Cout, Ovf, Out_valid, Count
  );

  modport slave (
    input  En, Clr, Ain, Bin,
    output Cout, Ovf, Out_valid, Count
  );
endinterface

// File: rtl/mac_lanes.sv
// Multi-lane two-stage multiply-accumulate: stage P registers products, stage A accumulates
// with optional signed arithmetic, saturation and a sticky per-lane overflow flag.
module mac_lanes #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  mac_lanes_if.slave   bus
);
  localparam int PW   = 2*DATA_WIDTH;
  localparam bit IS_S = (SIGNED != 0);
  localparam bit IS_T = (SATURATE != 0);

  logic                 r_en_p;
  logic                 r_clr_p;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_count;
  logic [NUM_LANES-1:0] r_ovf;
  logic [NUM_LANES-1:0] w_ovf;

  logic [PW-1:0]        w_ax   [NUM_LANES];
  logic [PW-1:0]        w_bx   [NUM_LANES];
  logic [PW-1:0]        w_prod [NUM_LANES];
  logic [PW-1:0]        r_prod [NUM_LANES];
  logic [ACC_WIDTH-1:0] w_ext  [NUM_LANES];
  logic [ACC_WIDTH-1:0] w_sat  [NUM_LANES];
  logic [ACC_WIDTH-1:0] w_next [NUM_LANES];
  logic [ACC_WIDTH-1:0] r_acc  [NUM_LANES];
  logic [ACC_WIDTH:0]   w_sum  [NUM_LANES];

  always_comb begin
    w_ovf = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      // Operands widened to product width first so the truncated product is exact in both modes
      w_ax[i] = (IS_S && bus.Ain[i*DATA_WIDTH + DATA_WIDTH - 1]) ? '1 : '0;
      w_ax[i][DATA_WIDTH-1:0] = bus.Ain[i*DATA_WIDTH +: DATA_WIDTH];
      w_bx[i] = (IS_S && bus.Bin[i*DATA_WIDTH + DATA_WIDTH - 1]) ? '1 : '0;
      w_bx[i][DATA_WIDTH-1:0] = bus.Bin[i*DATA_WIDTH +: DATA_WIDTH];
      w_prod[i] = w_ax[i] * w_bx[i];

      w_ext[i] = (IS_S && r_prod[i][PW-1]) ? '1 : '0;
      w_ext[i][PW-1:0] = r_prod[i];
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, w_ext[i]};

      if (IS_S)
        w_ovf[i] = (r_acc[i][ACC_WIDTH-1] == w_ext[i][ACC_WIDTH-1]) &&
                   (w_sum[i][ACC_WIDTH-1] != r_acc[i][ACC_WIDTH-1]);
      else
        w_ovf[i] = w_sum[i][ACC_WIDTH];

      // Signed overflow direction follows the (shared) operand sign: negative -> min, else max
      if (IS_S) begin
        w_sat[i] = {ACC_WIDTH{~r_acc[i][ACC_WIDTH-1]}};
        w_sat[i][ACC_WIDTH-1] = r_acc[i][ACC_WIDTH-1];
      end else begin
        w_sat[i] = '1;
      end

      w_next[i] = (w_ovf[i] && IS_T) ? w_sat[i] : w_sum[i][ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_p  <= 1'b0;
      r_clr_p <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_ovf   <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        r_prod[i] <= '0;
        r_acc[i]  <= '0;
      end
    end else begin
      r_en_p  <= bus.En;
      r_clr_p <= bus.Clr;
      r_valid <= r_en_p;
      for (int unsigned i = 0; i < NUM_LANES; i++)
        r_prod[i] <= w_prod[i];

      if (r_clr_p) begin
        r_ovf   <= '0;
        r_count <= r_en_p ? CNT_WIDTH'(1) : '0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
          r_acc[i] <= r_en_p ? w_ext[i] : '0;
      end else if (r_en_p) begin
        r_ovf <= r_ovf | w_ovf;
        if (r_count != '1)
          r_count <= r_count + 1'b1;
        for (int unsigned i = 0; i < NUM_LANES; i++)
          r_acc[i] <= w_next[i];
      end
    end
  end

  always_comb begin
    bus.Cout = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++)
      bus.Cout[i*ACC_WIDTH +: ACC_WIDTH] = r_acc[i];
  end

  assign bus.Ovf       = r_ovf;
  assign bus.Out_valid = r_valid;
  assign bus.Count     = r_count;
endmodule

// File: tb/tb_mac_lanes.sv
// Directed bench for mac_lanes: a default 4-lane unsigned instance plus 16-bit accumulator
// instances for unsigned saturate, unsigned wrap and signed saturate.
module tb_mac_lanes;
  logic        clk = 1'b0;
  logic        rst;
  logic        en, clr;
  logic [31:0] ain, bin;
  logic [15:0] sain, sbin;
  int errors = 0;
  int checks = 0;
  longint sum_cur [4];
  longint sum_prev[4];

  always #5 clk = ~clk;

  mac_lanes_if #(.DATA_WIDTH(8), .NUM_LANES(4), .ACC_WIDTH(24), .CNT_WIDTH(16)) if0 ();
  mac_lanes_if #(.DATA_WIDTH(8), .NUM_LANES(1), .ACC_WIDTH(16), .CNT_WIDTH(16)) if1 ();
  mac_lanes_if #(.DATA_WIDTH(8), .NUM_LANES(1), .ACC_WIDTH(16), .CNT_WIDTH(16)) if2 ();
  mac_lanes_if #(.DATA_WIDTH(8), .NUM_LANES(2), .ACC_WIDTH(16), .CNT_WIDTH(16)) if3 ();

  assign if0.En = en;  assign if0.Clr = clr;  assign if0.Ain = ain;      assign if0.Bin = bin;
  assign if1.En = en;  assign if1.Clr = clr;  assign if1.Ain = ain[7:0]; assign if1.Bin = bin[7:0];
  assign if2.En = en;  assign if2.Clr = clr;  assign if2.Ain = ain[7:0]; assign if2.Bin = bin[7:0];
  assign if3.En = en;  assign if3.Clr = clr;  assign if3.Ain = sain;     assign if3.Bin = sbin;

  mac_lanes #(.DATA_WIDTH(8), .NUM_LANES(4), .ACC_WIDTH(24), .SIGNED(0), .SATURATE(1), .CNT_WIDTH(16))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  mac_lanes #(.DATA_WIDTH(8), .NUM_LANES(1), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1), .CNT_WIDTH(16))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  mac_lanes #(.DATA_WIDTH(8), .NUM_LANES(1), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0), .CNT_WIDTH(16))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  mac_lanes #(.DATA_WIDTH(8), .NUM_LANES(2), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1), .CNT_WIDTH(16))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pack4(input longint s[4]);
    logic [95:0] v;
    for (int l = 0; l < 4; l++) v[l*24 +: 24] = s[l][23:0];
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    ain = '0; bin = '0; sain = '0; sbin = '0;
    for (int l = 0; l < 4; l++) begin sum_cur[l] = 0; sum_prev[l] = 0; end

    // Reset and hold
    repeat (5) step();
    chk("rst_cout",  128'(if0.Cout), 128'(0));
    chk("rst_ovf",   128'(if0.Ovf), 128'(0));
    chk("rst_count", 128'(if0.Count), 128'(0));
    chk("rst_valid", 128'(if0.Out_valid), 128'(0));
    rst = 1'b0;
    ain = 32'h11111111; bin = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_cout",  128'(if0.Cout), 128'(0));
      chk("hold_valid", 128'(if0.Out_valid), 128'(0));
      chk("hold_count", 128'(if0.Count), 128'(0));
      chk("hold_ovf",   128'(if0.Ovf), 128'(0));
    end

    // Latency across lanes
    ain = {8'd255, 8'd7, 8'd5, 8'd3};
    bin = {8'd255, 8'd8, 8'd6, 8'd4};
    en = 1'b1;
    step();
    en = 1'b0;
    chk("lat_valid_early", 128'(if0.Out_valid), 128'(0));
    step();
    chk("lat_cout",  128'(if0.Cout), 128'({24'd65025, 24'd56, 24'd30, 24'd12}));
    chk("lat_valid", 128'(if0.Out_valid), 128'(1));
    chk("lat_count", 128'(if0.Count), 128'(1));
    step();
    chk("lat_valid_drop", 128'(if0.Out_valid), 128'(0));
    chk("lat_hold",       128'(if0.Cout), 128'({24'd65025, 24'd56, 24'd30, 24'd12}));

    // Clr alone, then Clr ordering
    clr = 1'b1; step(); clr = 1'b0; step();
    chk("clr_cout",  128'(if0.Cout), 128'(0));
    chk("clr_valid", 128'(if0.Out_valid), 128'(0));
    chk("clr_count", 128'(if0.Count), 128'(0));
    ain = 32'h02020202; bin = 32'h03030303; en = 1'b1;
    step();
    ain = 32'h04040404; bin = 32'h05050505; clr = 1'b1;
    step();
    en = 1'b0; clr = 1'b0;
    chk("ord_first",       128'(if0.Cout), 128'({4{24'd6}}));
    chk("ord_first_count", 128'(if0.Count), 128'(1));
    step();
    chk("ord_second",       128'(if0.Cout), 128'({4{24'd20}}));
    chk("ord_second_count", 128'(if0.Count), 128'(1));
    chk("ord_second_valid", 128'(if0.Out_valid), 128'(1));
    clr = 1'b1; step(); clr = 1'b0; step();
    chk("clr2_cout",  128'(if0.Cout), 128'(0));
    chk("clr2_valid", 128'(if0.Out_valid), 128'(0));

    // Random accumulate, 226 back-to-back operand sets
    for (int k = 0; k < 226; k++) begin
      for (int l = 0; l < 4; l++) begin
        ain[l*8 +: 8] = 8'($urandom_range(0, 127));
        bin[l*8 +: 8] = 8'($urandom_range(0, 127));
        sum_cur[l] += longint'(ain[l*8 +: 8]) * longint'(bin[l*8 +: 8]);
      end
      en = 1'b1;
      step();
      if (k > 0) begin
        chk("rand_cout",  128'(if0.Cout), 128'(pack4(sum_prev)));
        chk("rand_valid", 128'(if0.Out_valid), 128'(1));
      end
      sum_prev = sum_cur;
    end
    en = 1'b0;
    step();
    chk("rand_final", 128'(if0.Cout), 128'(pack4(sum_cur)));
    chk("rand_count", 128'(if0.Count), 128'(226));
    chk("rand_ovf",   128'(if0.Ovf), 128'(0));
    step();
    chk("rand_valid_drop", 128'(if0.Out_valid), 128'(0));

    // Saturation / wrap / signed clamps
    clr = 1'b1; step(); clr = 1'b0; step();
    ain = 32'h000000FF; bin = 32'h000000FF;
    sain = {8'h80, 8'h80}; sbin = {8'h7F, 8'h80};
    en = 1'b1;
    step();
    step();
    chk("sat1_u",    128'(if1.Cout), 128'(16'hFE01));
    chk("sat1_uovf", 128'(if1.Ovf), 128'(0));
    chk("sat1_w",    128'(if2.Cout), 128'(16'hFE01));
    chk("sat1_s",    128'(if3.Cout), 128'({16'hC080, 16'h4000}));
    chk("sat1_sovf", 128'(if3.Ovf), 128'(0));
    step();
    chk("sat2_u",    128'(if1.Cout), 128'(16'hFFFF));
    chk("sat2_uovf", 128'(if1.Ovf), 128'(1));
    chk("sat2_w",    128'(if2.Cout), 128'(16'hFC02));
    chk("sat2_wovf", 128'(if2.Ovf), 128'(1));
    chk("sat2_s",    128'(if3.Cout), 128'({16'h8100, 16'h7FFF}));
    chk("sat2_sovf", 128'(if3.Ovf), 128'(2'b01));
    sbin = {8'h7F, 8'h7F};
    step();
    chk("sat3_u",    128'(if1.Cout), 128'(16'hFFFF));
    chk("sat3_w",    128'(if2.Cout), 128'(16'hFA03));
    chk("sat3_s",    128'(if3.Cout), 128'({16'h8000, 16'h7FFF}));
    chk("sat3_sovf", 128'(if3.Ovf), 128'(2'b11));
    en = 1'b0;
    step();
    chk("sat4_u",     128'(if1.Cout), 128'(16'hFFFF));
    chk("sat4_ucount", 128'(if1.Count), 128'(4));
    chk("sat4_w",     128'(if2.Cout), 128'(16'hF804));
    chk("sat4_s",     128'(if3.Cout), 128'({16'h8000, 16'h407F}));
    chk("sat4_sovf",  128'(if3.Ovf), 128'(2'b11));
    step();
    chk("sat_hold_u", 128'(if1.Cout), 128'(16'hFFFF));

    // Asynchronous reset in the middle of back-to-back accumulation
    ain = 32'h09090909; bin = 32'h0A0A0A0A; en = 1'b1;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_cout",  128'(if0.Cout), 128'(0));
    chk("arst_valid", 128'(if0.Out_valid), 128'(0));
    chk("arst_count", 128'(if0.Count), 128'(0));
    chk("arst_ovf",   128'(if1.Ovf), 128'(0));
    en = 1'b0;
    step();
    rst = 1'b0;
    ain = {8'd255, 8'd7, 8'd5, 8'd3};
    bin = {8'd255, 8'd8, 8'd6, 8'd4};
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    chk("post_rst_cout",  128'(if0.Cout), 128'({24'd65025, 24'd56, 24'd30, 24'd12}));
    chk("post_rst_count", 128'(if0.Count), 128'(1));
    chk("post_rst_valid", 128'(if0.Out_valid), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_lanes.md
# mac_lanes

Multi-lane, pipelined multiply-accumulate engine; parametrised successor to the single-lane MAC_IP. NUM_LANES independent lanes share one enable/clear control stream, each multiplying DATA_WIDTH operands into an ACC_WIDTH accumulator. Adds selectable signed arithmetic, saturation, a sticky overflow flag, an output-valid strobe and an accumulation counter. Sits between the operand fetch logic and the result readout as the compute core of the datapath.

## Interface
- DATA_WIDTH, 8, operand width per lane
- NUM_LANES, 4, number of parallel lanes (1..16)
- ACC_WIDTH, 3*DATA_WIDTH, accumulator width per lane; must be >= 2*DATA_WIDTH
- SIGNED, 0, 1 = operands and accumulator are two's complement
- SATURATE, 1, 1 = accumulator clamps on overflow; 0 = wraps
- CNT_WIDTH, 16, accumulation counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- En  in  1  accept one operand set this cycle
- Clr  in  1  clear accumulators, Ovf and Count
- Ain  in  NUM_LANES*DATA_WIDTH  lane i operand at bits [i*DATA_WIDTH +: DATA_WIDTH]
- Bin  in  NUM_LANES*DATA_WIDTH  same packing as Ain
- Cout  out  NUM_LANES*ACC_WIDTH  lane i accumulator at [i*ACC_WIDTH +: ACC_WIDTH]
- Ovf  out  NUM_LANES  per-lane sticky overflow flag
- Out_valid  out  1  one-cycle strobe: Cout updated by an accumulation
- Count  out  CNT_WIDTH  accumulations since last Clr/reset

## Operation
- Two pipeline stages. Stage 1 (P): registers per-lane product Ain*Bin (2*DATA_WIDTH, signed or unsigned per SIGNED) plus en_p, clr_p. Stage 2 (A): accumulate.
- Stage 2 per lane, evaluated on each edge from en_p/clr_p:
  - clr_p=1, en_p=0: acc <- 0, Ovf <- 0, Count <- 0.
  - clr_p=1, en_p=1: acc <- sign/zero-extended product, Ovf <- 0, Count <- 1 (clear-then-load).
  - clr_p=0, en_p=1: acc <- acc + ext(product); Count <- Count+1.
  - both 0: hold all.
- Sum computed at ACC_WIDTH+1 bits. Overflow: unsigned = carry out; signed = operands same sign, result sign differs.
- On overflow: SATURATE=1 clamps to max (unsigned all ones; signed 0111..1) or signed min (100..0); SATURATE=0 keeps wrapped result. Ovf[i] set either way, sticky until Clr or rst.
- Once saturated, further same-direction adds hold the clamp; opposite-sign adds proceed from the clamped value.
- Count saturates at all ones; never wraps.
- Out_valid <- en_p (registered alongside accumulator).
- En and Clr are never back-pressured; one operand set accepted every cycle En=1.

## Timing
- Reset (rst=1, any time, asynchronous): all pipeline registers, Cout, Ovf, Count, Out_valid = 0. Operations in flight are discarded; first En after deassert behaves as from empty.
- Latency: En/Clr sampled at edge N; Cout, Ovf, Count, Out_valid reflect it after edge N+1. Throughput one set per cycle.
- Clr is pipelined with En, so ordering is preserved: an En at N followed by Clr at N+1 accumulates, then clears.
- Out_valid high exactly one cycle per accepted En; back-to-back En gives continuous Out_valid.
- Clr alone does not raise Out_valid.
- Outputs hold indefinitely with En=Clr=0.
- No combinational path input to output.

## Test plan
- Reset/hold: rst high 5 cycles, release, Ain=Bin=0x11 all lanes with En=0 for 3 cycles -> Cout=0, Ovf=0, Count=0, Out_valid never high.
- Latency/lanes: NUM_LANES=4, unsigned, one En with lanes A={3,5,7,255}, B={4,6,8,255} -> two edges later Cout={12,30,56,65025}, Out_valid one cycle, Count=1.
- Random accumulate: 226 consecutive En cycles, random operands 0..127 per lane, model running sum -> every Out_valid cycle Cout matches model, Count=226, Ovf=0.
- Clr ordering: En(A=2,B=3), next cycle Clr+En(A=4,B=5) -> Cout=6 then 20, Count=1; Clr alone then -> Cout=0, Out_valid low.
- Saturation: DATA_WIDTH=8, ACC_WIDTH=16, SATURATE=1, unsigned, 255*255 repeated -> after 2nd add Cout=0xFFFF, Ovf=1, stays 0xFFFF; SATURATE=0 -> Cout=0xFC02, Ovf=1. Signed: -128*-128 repeated with ACC_WIDTH=16 -> clamps 0x7FFF; -128*127 repeated -> clamps 0x8000.
- Async reset mid-stream: assert rst between edges during back-to-back En -> outputs 0 immediately; after release first En yields Cout=single product, Count=1.
